// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer in front of a synchronous single-port RAM, with lock for atomic RMW.
// Define RAM_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [1:0]            i_req_we,
    input  logic [1:0]            i_req_lock,
    input  logic [ADDR_WIDTH-1:0] i_req_addr0,
    input  logic [ADDR_WIDTH-1:0] i_req_addr1,
    input  logic [DATA_WIDTH-1:0] i_req_wdata0,
    input  logic [DATA_WIDTH-1:0] i_req_wdata1,
    output logic [1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_din,
    output logic                  o_ram_we,
    input  logic [DATA_WIDTH-1:0] i_ram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } lock_state_t;

    lock_state_t r_state;
    logic [1:0]  r_rsp_valid;
    logic [1:0]  w_grant;
    logic        w_prefer1;

`ifdef RAM_ARB_RR_EN
    logic r_last_grant;

    // Reset value 1 makes requester 0 the favoured one; frozen while a lock is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (r_state == IDLE && |w_grant) begin
            r_last_grant <= w_grant[1];
        end
    end

    assign w_prefer1 = ~r_last_grant;
`else
    assign w_prefer1 = 1'b0;
`endif

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        w_grant = 2'b00;
        if (!i_rst) begin
            case (r_state)
                OWN0:    w_grant[0] = i_req_valid[0];
                OWN1:    w_grant[1] = i_req_valid[1];
                default: begin
                    if (&i_req_valid) begin
                        w_grant = w_prefer1 ? 2'b10 : 2'b01;
                    end else begin
                        w_grant = i_req_valid;
                    end
                end
            endcase
        end
    end

    assign o_req_ready = w_grant;
    assign o_ram_we    = |(w_grant & i_req_we);
    assign o_ram_addr  = w_grant[1] ? i_req_addr1  : i_req_addr0;
    assign o_ram_din   = w_grant[1] ? i_req_wdata1 : i_req_wdata0;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_rsp_valid <= 2'b00;
        end else begin
            r_rsp_valid <= w_grant & ~i_req_we;
            if (w_grant[0]) begin
                r_state <= i_req_lock[0] ? OWN0 : IDLE;
            end else if (w_grant[1]) begin
                r_state <= i_req_lock[1] ? OWN1 : IDLE;
            end
        end
    end

    // Gating by reset drops a read response that would land while reset is asserted.
    assign o_rsp_valid = i_rst ? 2'b00 : r_rsp_valid;
    assign o_rsp_rdata = i_ram_dout;

endmodule
